pipe_cpu_5stage: RTL and testbench
==================================

Name: pipe_cpu_5stage

Overview:
- Five-stage in-order pipelined 32-bit MIPS-subset CPU: IF, ID, EX, MEM, WB.
- Contains its own instruction memory, register file and data memory, so the top level has only clock and reset.
- Benches preload programs and inspect state hierarchically. Required instance and array names:
  - IM.Instr_Mem: 32-bit words, loaded with $readmemb.
  - RF.Reg_File[0..31]: 32-bit registers.
  - DM.memory[0..31]: 32-bit words.

Parameters:
- IM_DEPTH, 128, instruction memory depth in 32-bit words.
- DM_DEPTH, 32, data memory depth in 32-bit words.

Ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-high reset (1 = reset asserted); port name kept per codebase convention.

Behaviour:
- Reset, asynchronous while rst_n=1:
  - PC=0.
  - All pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) cleared; the cleared state is a NOP with all write enables 0.
  - RF all zero.
  - IM and DM contents untouched. DM initialises to all zero at time 0.
- Instruction set:
  - R-type: add, sub, and, or, slt (funct 0x20, 0x22, 0x24, 0x25, 0x2A).
  - I-type: addi (0x08), slti (0x0A), lw (0x23), sw (0x2B), beq (0x04).
  - The all-zero word is a NOP.
  - Any other opcode is treated as a NOP: no RF or DM write.
- Immediates are sign-extended to 32 bits. Arithmetic is 32-bit two's complement with overflow ignored; slt and slti compare signed.
- Addressing:
  - IM is word-indexed by PC[8:2].
  - DM is word-indexed by ALU result[6:2]; the low two address bits are ignored. Out-of-range addresses wrap modulo depth.
- Register file:
  - Written on the rising edge in WB.
  - Register 0 is hardwired to 0; writes to it are discarded.
  - Internal bypass: an ID read of the register being written that cycle returns the new value.
- Timing:
  - Instruction fetched in cycle n reads RF in n+1, executes in n+2, accesses DM in n+3, and commits its RF write at the end of n+4.
  - sw writes DM at the end of its MEM cycle.
  - lw data is available from DM combinationally in MEM and is registered into MEM/WB.
- PC increments by 4 every cycle. There is no stall logic and no hazard detection.
- beq:
  - Target = PC+4 + (sign-extended imm << 2).
  - Resolved in MEM: when taken, PC loads the target on that edge.
  - The three younger instructions already in flight are NOT flushed. Software must place three NOPs after every beq.
- Without FORWARDING_EN, software must separate a producer from a dependent consumer by at least 2 instructions. The RF bypass covers distance 3.
- Load-use hazards are never interlocked in either build; software must separate lw from a dependent instruction by at least 1 instruction when forwarding is enabled.
- Reset asserted mid-program discards all in-flight instructions. RF is zeroed; DM writes already committed persist. Execution restarts at PC=0 on the first rising edge after deassertion.

Optional Feature:
- Macro: PIPE_CPU_FORWARDING_EN.
- When defined, a forwarding unit selects each EX ALU operand. Priority order:
  1. EX/MEM result, if its RegWrite=1, rd≠0 and rd matches the source.
  2. MEM/WB write data, under the same conditions.
  3. ID/EX register value.
- Forwarding also applies to sw store data.
- When not defined, no forwarding path exists and the ALU uses ID/EX values only.

Test Plan:
- Independent ops: addi r1,r0,5; addi r2,r0,7; 3 NOPs; add r3,r1,r2; sub r4,r2,r1; 4 NOPs -> r1=5, r2=7, r3=12, r4=2.
- Memory: r3=12, r1=5 preset; sw r3,4(r0); NOPs; lw r5,4(r0); 4 NOPs -> DM.memory[1]=12, r5=12, other DM words 0.
- Logic and compare: r1=5, r2=7; and r6,r1,r2; or r7,r1,r2; slt r8,r1,r2; slti r9,r2,-1 -> r6=5, r7=7, r8=1, r9=0; write to r0 leaves r0=0.
- Branch: beq r0,r0,+4 followed by 3 NOPs and addi r10,r0,1, with addi r11,r0,9 at the target -> r10=0, r11=9.
- Dependence:
  - Forwarding build: addi r1,r0,3; add r2,r1,r1 back-to-back -> r2=6.
  - Non-forwarding build: same sequence -> r2=0; with two NOPs inserted -> r2=6.
- Reset mid-run: assert rst_n=1 at cycle 10 for one cycle -> RF all 0 immediately, PC restarts at 0, program re-runs to the same final RF values.

Source files
------------

// File: rtl/pipe_cpu_5stage.sv
// Five-stage in-order MIPS-subset CPU (IF, ID, EX, MEM, WB) with internal
// instruction memory, register file and data memory.
// Optional build macro: PIPE_CPU_FORWARDING_EN adds an EX-stage forwarding
// unit for both ALU operands and sw store data.
// No hazard detection or stalls; beq resolves in MEM without flushing.
module pipe_cpu_5stage #(
  parameter int unsigned IM_DEPTH = 128,
  parameter int unsigned DM_DEPTH = 32
) (
  input logic clk_i,
  input logic rst_n  // active-high asynchronous reset
);

  localparam int unsigned ImAw = $clog2(IM_DEPTH);
  localparam int unsigned DmAw = $clog2(DM_DEPTH);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluSlt
  } alu_op_e;

  // All-zero value of this struct is the NOP control word.
  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_write;
    logic    branch;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  // ---------------- pipeline state ----------------
  logic [31:0] pc_q, pc_d;

  logic [31:0] if_id_instr, if_id_pc4;

  ctrl_t       id_ex_ctrl;
  logic [31:0] id_ex_rs_val, id_ex_rt_val, id_ex_imm, id_ex_pc4;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dst;

  logic        ex_mem_reg_write, ex_mem_mem_to_reg, ex_mem_mem_write;
  logic        ex_mem_br_taken;
  logic [31:0] ex_mem_alu, ex_mem_store, ex_mem_br_target;
  logic [4:0]  ex_mem_dst;

  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_dst;
  logic [31:0] mem_wb_data;

  // ---------------- IF ----------------
  logic [31:0] if_instr, if_pc4;

  if (1) begin : IM
    logic [31:0] Instr_Mem [0:IM_DEPTH-1];
  end

  assign if_instr = IM.Instr_Mem[pc_q[ImAw+1:2]];
  assign if_pc4   = pc_q + 32'd4;

  // ---------------- ID ----------------
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_dst;
  logic [31:0] id_imm, id_rs_val, id_rt_val;
  ctrl_t       id_ctrl;
  logic        unused_shamt;

  assign id_opcode    = if_id_instr[31:26];
  assign id_rs        = if_id_instr[25:21];
  assign id_rt        = if_id_instr[20:16];
  assign id_rd        = if_id_instr[15:11];
  assign id_funct     = if_id_instr[5:0];
  assign id_imm       = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
  assign unused_shamt = ^if_id_instr[10:6];

  // Decode: anything not recognised leaves the NOP control word.
  always_comb begin
    id_ctrl = '0;
    id_dst  = id_rt;
    case (id_opcode)
      OpRtype: begin
        id_dst = id_rd;
        case (id_funct)
          6'h20: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = AluAdd; end
          6'h22: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = AluSub; end
          6'h24: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = AluAnd; end
          6'h25: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = AluOr;  end
          6'h2A: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = AluSlt; end
          default: ;
        endcase
      end
      OpAddi: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
        id_ctrl.alu_op    = AluAdd;
      end
      OpSlti: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
        id_ctrl.alu_op    = AluSlt;
      end
      OpLw: begin
        id_ctrl.reg_write  = 1'b1;
        id_ctrl.mem_to_reg = 1'b1;
        id_ctrl.alu_src    = 1'b1;
        id_ctrl.alu_op     = AluAdd;
      end
      OpSw: begin
        id_ctrl.mem_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
        id_ctrl.alu_op    = AluAdd;
      end
      OpBeq: begin
        id_ctrl.branch = 1'b1;
        id_ctrl.alu_op = AluSub;
      end
      default: ;
    endcase
  end

  if (1) begin : RF
    logic [31:0] Reg_File [0:31];

    // Register file write in WB; r0 is never written so it stays zero.
    always_ff @(posedge clk_i or posedge rst_n) begin
      if (rst_n) begin
        for (int i = 0; i < 32; i++) Reg_File[i] <= '0;
      end else if (mem_wb_reg_write && (mem_wb_dst != 5'd0)) begin
        Reg_File[mem_wb_dst] <= mem_wb_data;
      end
    end
  end

  // Read with write-through bypass so a same-cycle WB write is seen in ID.
  always_comb begin
    id_rs_val = RF.Reg_File[id_rs];
    id_rt_val = RF.Reg_File[id_rt];
    if (mem_wb_reg_write && (mem_wb_dst != 5'd0) && (mem_wb_dst == id_rs)) id_rs_val = mem_wb_data;
    if (mem_wb_reg_write && (mem_wb_dst != 5'd0) && (mem_wb_dst == id_rt)) id_rt_val = mem_wb_data;
  end

  // ---------------- EX ----------------
  logic [31:0] ex_op_a, ex_rt_fwd, ex_op_b, ex_alu, ex_br_target;
  logic        ex_br_taken;

`ifdef PIPE_CPU_FORWARDING_EN
  // Forwarding unit: the younger producer (EX/MEM) wins over MEM/WB.
  always_comb begin
    ex_op_a   = id_ex_rs_val;
    ex_rt_fwd = id_ex_rt_val;
    if (ex_mem_reg_write && (ex_mem_dst != 5'd0) && (ex_mem_dst == id_ex_rs)) begin
      ex_op_a = ex_mem_alu;
    end else if (mem_wb_reg_write && (mem_wb_dst != 5'd0) && (mem_wb_dst == id_ex_rs)) begin
      ex_op_a = mem_wb_data;
    end
    if (ex_mem_reg_write && (ex_mem_dst != 5'd0) && (ex_mem_dst == id_ex_rt)) begin
      ex_rt_fwd = ex_mem_alu;
    end else if (mem_wb_reg_write && (mem_wb_dst != 5'd0) && (mem_wb_dst == id_ex_rt)) begin
      ex_rt_fwd = mem_wb_data;
    end
  end
`else
  logic unused_fwd;
  assign ex_op_a    = id_ex_rs_val;
  assign ex_rt_fwd  = id_ex_rt_val;
  assign unused_fwd = ^{id_ex_rs, id_ex_rt};
`endif

  assign ex_op_b = id_ex_ctrl.alu_src ? id_ex_imm : ex_rt_fwd;

  // ALU; overflow is ignored, slt/slti compare signed.
  always_comb begin
    ex_alu = '0;
    case (id_ex_ctrl.alu_op)
      AluAdd:  ex_alu = ex_op_a + ex_op_b;
      AluSub:  ex_alu = ex_op_a - ex_op_b;
      AluAnd:  ex_alu = ex_op_a & ex_op_b;
      AluOr:   ex_alu = ex_op_a | ex_op_b;
      AluSlt:  ex_alu = {31'd0, $signed(ex_op_a) < $signed(ex_op_b)};
      default: ex_alu = '0;
    endcase
  end

  assign ex_br_taken  = id_ex_ctrl.branch && (ex_op_a == ex_op_b);
  assign ex_br_target = id_ex_pc4 + {id_ex_imm[29:0], 2'b00};

  // ---------------- MEM ----------------
  logic [31:0] mem_rdata;

  if (1) begin : DM
    logic [31:0] memory [0:DM_DEPTH-1];

    // Store commits at the end of the MEM cycle; contents survive reset.
    always_ff @(posedge clk_i) begin
      if (ex_mem_mem_write) memory[ex_mem_alu[DmAw+1:2]] <= ex_mem_store;
    end
  end

  assign mem_rdata = DM.memory[ex_mem_alu[DmAw+1:2]];

  // Taken beq redirects fetch from MEM; younger instructions are not flushed.
  assign pc_d = ex_mem_br_taken ? ex_mem_br_target : if_pc4;

  // ---------------- pipeline registers ----------------
  // PC and all inter-stage registers; reset leaves a NOP in every stage.
  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      pc_q              <= '0;
      if_id_instr       <= '0;
      if_id_pc4         <= '0;
      id_ex_ctrl        <= '0;
      id_ex_rs_val      <= '0;
      id_ex_rt_val      <= '0;
      id_ex_imm         <= '0;
      id_ex_pc4         <= '0;
      id_ex_rs          <= '0;
      id_ex_rt          <= '0;
      id_ex_dst         <= '0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_to_reg <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
      ex_mem_br_taken   <= 1'b0;
      ex_mem_alu        <= '0;
      ex_mem_store      <= '0;
      ex_mem_br_target  <= '0;
      ex_mem_dst        <= '0;
      mem_wb_reg_write  <= 1'b0;
      mem_wb_dst        <= '0;
      mem_wb_data       <= '0;
    end else begin
      pc_q              <= pc_d;
      if_id_instr       <= if_instr;
      if_id_pc4         <= if_pc4;
      id_ex_ctrl        <= id_ctrl;
      id_ex_rs_val      <= id_rs_val;
      id_ex_rt_val      <= id_rt_val;
      id_ex_imm         <= id_imm;
      id_ex_pc4         <= if_id_pc4;
      id_ex_rs          <= id_rs;
      id_ex_rt          <= id_rt;
      id_ex_dst         <= id_dst;
      ex_mem_reg_write  <= id_ex_ctrl.reg_write;
      ex_mem_mem_to_reg <= id_ex_ctrl.mem_to_reg;
      ex_mem_mem_write  <= id_ex_ctrl.mem_write;
      ex_mem_br_taken   <= ex_br_taken;
      ex_mem_alu        <= ex_alu;
      ex_mem_store      <= ex_rt_fwd;
      ex_mem_br_target  <= ex_br_target;
      ex_mem_dst        <= id_ex_dst;
      mem_wb_reg_write  <= ex_mem_reg_write;
      mem_wb_dst        <= ex_mem_dst;
      mem_wb_data       <= ex_mem_mem_to_reg ? mem_rdata : ex_mem_alu;
    end
  end

endmodule

// File: tb/tb_pipe_cpu_5stage.sv
// Directed self-checking bench for pipe_cpu_5stage. Programs are written
// straight into IM.Instr_Mem while reset is held; results are read from
// RF.Reg_File and DM.memory. Expectations follow PIPE_CPU_FORWARDING_EN.
module tb_pipe_cpu_5stage;

  logic clk_i;
  logic rst_n;

  int n_cmp  = 0;
  int n_fail = 0;
  int pidx   = 0;

  pipe_cpu_5stage dut (
    .clk_i (clk_i),
    .rst_n (rst_n)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {6'd0, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input int imm);
    logic [15:0] im;
    im = imm[15:0];
    return {op, rs, rt, im};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold reset and clear IM so a new program can be written.
  task automatic begin_prog();
    @(negedge clk_i);
    rst_n = 1'b1;
    for (int i = 0; i < 128; i++) dut.IM.Instr_Mem[i] = 32'd0;
    pidx = 0;
  endtask

  task automatic emit(input logic [31:0] w);
    dut.IM.Instr_Mem[pidx] = w;
    pidx++;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) emit(32'd0);
  endtask

  task automatic run(input int cycles);
    @(negedge clk_i);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk_i);
  endtask

  function automatic logic [31:0] rf(input int r);
    return dut.RF.Reg_File[r];
  endfunction

  task automatic prog_indep();
    emit(i_type(6'h08, 0, 1, 5));
    emit(i_type(6'h08, 0, 2, 7));
    nops(3);
    emit(r_type(1, 2, 3, 6'h20));
    emit(r_type(2, 1, 4, 6'h22));
    nops(4);
  endtask

  initial begin
    logic [31:0] e_r2, e_r6, e_r8, e_m3;
`ifdef PIPE_CPU_FORWARDING_EN
    e_r2 = 32'd6; e_r6 = 32'd4; e_r8 = 32'd4; e_m3 = 32'd11;
`else
    e_r2 = 32'd0; e_r6 = 32'd0; e_r8 = 32'd0; e_m3 = 32'd0;
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk_i);
    check("reset_pc", dut.pc_q, 32'd0);
    check("reset_r1", rf(1), 32'd0);

    // Memory: store/load, low address bits ignored, wrap modulo depth.
    begin_prog();
    emit(i_type(6'h08, 0, 3, 12));
    emit(i_type(6'h08, 0, 1, 5));
    nops(2);
    emit(i_type(6'h2B, 0, 3, 4));     // sw r3,4(r0)
    emit(i_type(6'h2B, 0, 1, 136));   // sw r1,136(r0) -> word 2
    nops(1);
    emit(i_type(6'h23, 0, 5, 4));     // lw r5,4(r0)
    emit(i_type(6'h23, 0, 6, 7));     // lw r6,7(r0)
    nops(4);
    run(20);
    check("mem_dm1", dut.DM.memory[1], 32'd12);
    check("mem_dm2_wrap", dut.DM.memory[2], 32'd5);
    check("mem_lw_r5", rf(5), 32'd12);
    check("mem_lw_r6_lowbits", rf(6), 32'd12);
    check("mem_dm0", dut.DM.memory[0], 32'd0);
    check("mem_dm31", dut.DM.memory[31], 32'd0);

    // Independent arithmetic.
    begin_prog();
    prog_indep();
    run(16);
    check("ind_r1", rf(1), 32'd5);
    check("ind_r2", rf(2), 32'd7);
    check("ind_r3", rf(3), 32'd12);
    check("ind_r4", rf(4), 32'd2);
    check("ind_r5_cleared", rf(5), 32'd0);

    // Logic, compare, r0 handling, undefined encodings.
    begin_prog();
    emit(i_type(6'h08, 0, 1, 5));
    emit(i_type(6'h08, 0, 2, 7));
    nops(3);
    emit(r_type(1, 2, 6, 6'h24));
    emit(r_type(1, 2, 7, 6'h25));
    emit(r_type(1, 2, 8, 6'h2A));
    emit(i_type(6'h0A, 2, 9, -1));
    emit(r_type(1, 2, 13, 6'h22));
    emit(i_type(6'h08, 0, 0, 9));     // write to r0
    emit(i_type(6'h08, 0, 11, 2));
    nops(1);
    emit(i_type(6'h08, 0, 10, 1));
    emit(i_type(6'h08, 0, 15, -3));
    emit(r_type(2, 1, 12, 6'h2A));
    emit(i_type(6'h3F, 0, 14, 5));    // unknown opcode
    emit(r_type(1, 2, 16, 6'h21));    // unknown funct
    nops(4);
    run(28);
    check("log_and", rf(6), 32'd5);
    check("log_or", rf(7), 32'd7);
    check("log_slt", rf(8), 32'd1);
    check("log_slti_neg", rf(9), 32'd0);
    check("log_sub_neg", rf(13), 32'hFFFF_FFFE);
    check("log_r0", rf(0), 32'd0);
    check("log_r0_bypass", rf(10), 32'd1);
    check("log_r0_fwd", rf(11), 32'd2);
    check("log_addi_sext", rf(15), 32'hFFFF_FFFD);
    check("log_slt_false", rf(12), 32'd0);
    check("log_bad_op", rf(14), 32'd0);
    check("log_bad_funct", rf(16), 32'd0);

    // Branch taken and not taken.
    begin_prog();
    emit(i_type(6'h04, 0, 0, 4));     // beq r0,r0,+4 -> word 5
    nops(3);
    emit(i_type(6'h08, 0, 10, 1));
    emit(i_type(6'h08, 0, 11, 9));
    nops(3);
    emit(i_type(6'h04, 11, 0, 4));    // not taken
    nops(3);
    emit(i_type(6'h08, 0, 12, 3));
    emit(i_type(6'h08, 0, 14, 4));
    nops(4);
    run(28);
    check("br_skipped", rf(10), 32'd0);
    check("br_target", rf(11), 32'd9);
    check("br_not_taken", rf(12), 32'd3);
    check("br_after", rf(14), 32'd4);

    // Dependences.
    begin_prog();
    emit(i_type(6'h08, 0, 1, 3));
    emit(r_type(1, 1, 2, 6'h20));     // distance 1
    emit(i_type(6'h08, 0, 3, 4));
    nops(2);
    emit(r_type(3, 3, 4, 6'h20));     // distance 3, RF bypass
    emit(i_type(6'h08, 0, 5, 2));
    nops(1);
    emit(r_type(5, 5, 6, 6'h20));     // distance 2
    emit(i_type(6'h08, 0, 7, 1));
    emit(i_type(6'h08, 0, 7, 2));
    emit(r_type(7, 7, 8, 6'h20));     // newest producer must win
    emit(i_type(6'h08, 0, 9, 11));
    emit(i_type(6'h2B, 0, 9, 12));    // sw r9,12(r0)
    nops(4);
    run(28);
    check("dep_d1", rf(2), e_r2);
    check("dep_d3", rf(4), 32'd8);
    check("dep_d2", rf(6), e_r6);
    check("dep_prio", rf(8), e_r8);
    check("dep_r9", rf(9), 32'd11);
    check("dep_sw", dut.DM.memory[3], e_m3);

    // Reset mid-run.
    begin_prog();
    prog_indep();
    run(10);
    check("rst_pre_r1", rf(1), 32'd5);
    rst_n = 1'b1;
    #1;
    check("rst_r1", rf(1), 32'd0);
    check("rst_r2", rf(2), 32'd0);
    check("rst_pc", dut.pc_q, 32'd0);
    run(16);
    check("rst_rerun_r1", rf(1), 32'd5);
    check("rst_rerun_r2", rf(2), 32'd7);
    check("rst_rerun_r3", rf(3), 32'd12);
    check("rst_rerun_r4", rf(4), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
